// File: rtl/dec_avg_stage.sv
// rtl/dec_avg_stage.sv - power-of-two moving average behind the sigma-delta decimator
// Optional MODE_NORM_EN: doubles (with saturation) MODE=1 samples so both windows share full scale.
module dec_avg_stage #(
    parameter int LOG2_DEPTH = 2,
    parameter int DW         = 16
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [DW-1:0] Q_IN,
    input  logic [15:0]   TIMER,
    input  logic          MODE,
    input  logic          READY,
    input  logic          OVR_CLR,
    output logic [DW-1:0] AVG,
    output logic          VALID,
    output logic          OVR,
    output logic          FILLED
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DW + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH+1)'(DEPTH);

    logic [DW-1:0]         r_buf [DEPTH];
    logic [SW-1:0]         r_sum;
    logic [LOG2_DEPTH:0]   r_fill;
    logic [LOG2_DEPTH-1:0] r_wp;
    logic                  r_hit;
    logic                  r_mode;

    logic                  w_hit;
    logic                  w_flush;
    logic                  w_capture;
    logic                  w_load;
    logic [DW-1:0]         w_sample;
    logic [DW-1:0]         w_old;
    logic [SW-1:0]         w_sum_next;
    logic [LOG2_DEPTH:0]   w_fill_next;

    assign w_hit   = (!MODE && TIMER == 16'hFFFF) || (MODE && TIMER == 16'h8000);
    assign w_flush = (MODE != r_mode);
    // Capture one cycle after the boundary, when the decimator output has settled.
    assign w_capture = r_hit && !w_flush;

`ifdef MODE_NORM_EN
    assign w_sample = MODE ? (Q_IN[DW-1] ? {DW{1'b1}} : {Q_IN[DW-2:0], 1'b0}) : Q_IN;
`else
    assign w_sample = Q_IN;
`endif

    assign FILLED = (r_fill == FILL_FULL);
    // Stale buffer entries after a flush are never subtracted until the ring refills.
    assign w_old       = FILLED ? r_buf[r_wp] : '0;
    assign w_sum_next  = r_sum + SW'(w_sample) - SW'(w_old);
    assign w_fill_next = FILLED ? r_fill : r_fill + 1'b1;
    assign w_load      = w_capture && (w_fill_next == FILL_FULL);

    always_ff @(posedge CLK) begin
        if (w_capture) begin
            r_buf[r_wp] <= w_sample;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_hit  <= 1'b0;
            r_mode <= 1'b0;
            r_sum  <= '0;
            r_fill <= '0;
            r_wp   <= '0;
            AVG    <= '0;
            VALID  <= 1'b0;
            OVR    <= 1'b0;
        end else begin
            r_hit  <= w_hit;
            r_mode <= MODE;

            if (w_flush) begin
                r_sum  <= '0;
                r_fill <= '0;
                r_wp   <= '0;
            end else if (r_hit) begin
                r_sum  <= w_sum_next;
                r_fill <= w_fill_next;
                r_wp   <= r_wp + 1'b1;
            end

            if (w_load) begin
                AVG   <= w_sum_next[SW-1:LOG2_DEPTH];
                VALID <= 1'b1;
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end

            // Overwrite of an unaccepted result sets OVR; set beats clear.
            if (w_load && VALID && !READY) begin
                OVR <= 1'b1;
            end else if (OVR_CLR) begin
                OVR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dec_avg_stage.sv
// tb/tb_dec_avg_stage.sv - directed-vector bench for dec_avg_stage
module tb_dec_avg_stage;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic [15:0] Q_IN;
    logic [15:0] TIMER;
    logic        MODE;
    logic        READY;
    logic        OVR_CLR;
    logic [15:0] AVG;
    logic        VALID;
    logic        OVR;
    logic        FILLED;

    int vectors = 0;
    int miscompares = 0;

    dec_avg_stage #(.LOG2_DEPTH(2), .DW(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .Q_IN(Q_IN), .TIMER(TIMER), .MODE(MODE),
        .READY(READY), .OVR_CLR(OVR_CLR), .AVG(AVG), .VALID(VALID),
        .OVR(OVR), .FILLED(FILLED)
    );

    always #5 CLK = ~CLK;

    task automatic apply_reset();
        RSTN = 1'b0; Q_IN = '0; TIMER = '0; MODE = 1'b0; READY = 1'b0; OVR_CLR = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTN = 1'b1;
    endtask

    // Boundary for one cycle, then READY=rdy just before the capture edge; returns #1 after it.
    task automatic do_sample(input logic [15:0] q, input logic rdy);
        TIMER = MODE ? 16'h8000 : 16'hFFFF;
        Q_IN  = q;
        @(posedge CLK); #1;
        TIMER = 16'h0000;
        READY = rdy;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (AVG !== 16'd0) begin $display("FAIL reset_avg got %0d want 0", AVG); miscompares++; end
        vectors++; if (VALID !== 1'b0) begin $display("FAIL reset_valid got %b want 0", VALID); miscompares++; end
        vectors++; if (OVR !== 1'b0) begin $display("FAIL reset_ovr got %b want 0", OVR); miscompares++; end
        vectors++; if (FILLED !== 1'b0) begin $display("FAIL reset_filled got %b want 0", FILLED); miscompares++; end
    endtask

    task automatic test_basic();
        logic [15:0] warm [3];
        apply_reset();
        READY = 1'b1;
        warm[0] = 16'd100; warm[1] = 16'd200; warm[2] = 16'd300;
        for (int i = 0; i < 3; i++) begin
            do_sample(warm[i], 1'b1);
            vectors++; if (VALID !== 1'b0) begin $display("FAIL basic_warm_valid[%0d] got %b want 0", i, VALID); miscompares++; end
            vectors++; if (FILLED !== 1'b0) begin $display("FAIL basic_warm_filled[%0d] got %b want 0", i, FILLED); miscompares++; end
        end
        do_sample(16'd400, 1'b1);
        vectors++; if (VALID !== 1'b1) begin $display("FAIL basic_first_valid got %b want 1", VALID); miscompares++; end
        vectors++; if (AVG !== 16'd250) begin $display("FAIL basic_first_avg got %0d want 250", AVG); miscompares++; end
        vectors++; if (FILLED !== 1'b1) begin $display("FAIL basic_filled got %b want 1", FILLED); miscompares++; end
        @(posedge CLK); #1;
        vectors++; if (VALID !== 1'b0) begin $display("FAIL basic_pulse_end got %b want 0", VALID); miscompares++; end
        do_sample(16'd500, 1'b1);
        vectors++; if (VALID !== 1'b1) begin $display("FAIL basic_second_valid got %b want 1", VALID); miscompares++; end
        vectors++; if (AVG !== 16'd350) begin $display("FAIL basic_second_avg got %0d want 350", AVG); miscompares++; end
        vectors++; if (OVR !== 1'b0) begin $display("FAIL basic_ovr got %b want 0", OVR); miscompares++; end
    endtask

    task automatic test_overrun();
        apply_reset();
        for (int i = 1; i <= 4; i++) do_sample(16'(100 * i), 1'b0);
        vectors++; if (AVG !== 16'd250) begin $display("FAIL ovr_first_avg got %0d want 250", AVG); miscompares++; end
        vectors++; if (OVR !== 1'b0) begin $display("FAIL ovr_not_yet got %b want 0", OVR); miscompares++; end
        do_sample(16'd500, 1'b0);
        vectors++; if (AVG !== 16'd350) begin $display("FAIL ovr_avg5 got %0d want 350", AVG); miscompares++; end
        vectors++; if (OVR !== 1'b1) begin $display("FAIL ovr_set got %b want 1", OVR); miscompares++; end
        do_sample(16'd600, 1'b0);
        vectors++; if (AVG !== 16'd450) begin $display("FAIL ovr_avg6 got %0d want 450", AVG); miscompares++; end
        vectors++; if (VALID !== 1'b1) begin $display("FAIL ovr_valid_held got %b want 1", VALID); miscompares++; end
        @(posedge CLK); #1;
        vectors++; if (AVG !== 16'd450) begin $display("FAIL ovr_avg_stable got %0d want 450", AVG); miscompares++; end
        OVR_CLR = 1'b1;
        @(posedge CLK); #1;
        OVR_CLR = 1'b0;
        vectors++; if (OVR !== 1'b0) begin $display("FAIL ovr_clear got %b want 0", OVR); miscompares++; end
        vectors++; if (VALID !== 1'b1) begin $display("FAIL ovr_clr_valid got %b want 1", VALID); miscompares++; end
        READY = 1'b1;
        @(posedge CLK); #1;
        READY = 1'b0;
        vectors++; if (VALID !== 1'b0) begin $display("FAIL ovr_drain got %b want 0", VALID); miscompares++; end
    endtask

    task automatic test_mode_flush();
        logic [15:0] exp_avg;
`ifdef MODE_NORM_EN
        exp_avg = 16'd2000;
`else
        exp_avg = 16'd1000;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) do_sample(16'd50, 1'b0);
        vectors++; if (AVG !== 16'd50) begin $display("FAIL flush_pre_avg got %0d want 50", AVG); miscompares++; end
        MODE = 1'b1;
        @(posedge CLK); #1;
        vectors++; if (FILLED !== 1'b0) begin $display("FAIL flush_filled got %b want 0", FILLED); miscompares++; end
        vectors++; if (VALID !== 1'b1) begin $display("FAIL flush_keeps_valid got %b want 1", VALID); miscompares++; end
        vectors++; if (AVG !== 16'd50) begin $display("FAIL flush_keeps_avg got %0d want 50", AVG); miscompares++; end
        READY = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) begin
            do_sample(16'd1000, 1'b1);
            vectors++; if (VALID !== 1'b0) begin $display("FAIL flush_warm_valid[%0d] got %b want 0", i, VALID); miscompares++; end
        end
        do_sample(16'd1000, 1'b1);
        vectors++; if (VALID !== 1'b1) begin $display("FAIL flush_new_valid got %b want 1", VALID); miscompares++; end
        vectors++; if (AVG !== exp_avg) begin $display("FAIL flush_new_avg got %0d want %0d", AVG, exp_avg); miscompares++; end
    endtask

`ifdef MODE_NORM_EN
    task automatic test_saturation();
        apply_reset();
        MODE = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) do_sample(16'h9000, 1'b1);
        vectors++; if (AVG !== 16'hFFFF) begin $display("FAIL sat_avg got %h want ffff", AVG); miscompares++; end
        vectors++; if (VALID !== 1'b1) begin $display("FAIL sat_valid got %b want 1", VALID); miscompares++; end
    endtask
`endif

    task automatic test_async_reset();
        logic [15:0] tail [4];
        apply_reset();
        for (int i = 0; i < 6; i++) do_sample(16'd40, 1'b0);
        vectors++; if (OVR !== 1'b1) begin $display("FAIL areset_pre_ovr got %b want 1", OVR); miscompares++; end
        do_sample(16'd8, 1'b0);
        do_sample(16'd8, 1'b0);
        #3;
        RSTN = 1'b0;
        #1;
        vectors++; if (AVG !== 16'd0) begin $display("FAIL areset_avg got %0d want 0", AVG); miscompares++; end
        vectors++; if (VALID !== 1'b0) begin $display("FAIL areset_valid got %b want 0", VALID); miscompares++; end
        vectors++; if (OVR !== 1'b0) begin $display("FAIL areset_ovr got %b want 0", OVR); miscompares++; end
        vectors++; if (FILLED !== 1'b0) begin $display("FAIL areset_filled got %b want 0", FILLED); miscompares++; end
        RSTN = 1'b1;
        @(posedge CLK); #1;
        READY = 1'b1;
        tail[0] = 16'd8; tail[1] = 16'd8; tail[2] = 16'd8; tail[3] = 16'd9;
        for (int i = 0; i < 3; i++) begin
            do_sample(tail[i], 1'b1);
            vectors++; if (VALID !== 1'b0) begin $display("FAIL areset_warm_valid[%0d] got %b want 0", i, VALID); miscompares++; end
        end
        do_sample(tail[3], 1'b1);
        vectors++; if (VALID !== 1'b1) begin $display("FAIL areset_valid_after got %b want 1", VALID); miscompares++; end
        vectors++; if (AVG !== 16'd8) begin $display("FAIL areset_trunc_avg got %0d want 8", AVG); miscompares++; end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 4; i++) do_sample(16'd10, 1'b0);
        vectors++; if (AVG !== 16'd10) begin $display("FAIL b2b_first_avg got %0d want 10", AVG); miscompares++; end
        do_sample(16'd30, 1'b1);
        vectors++; if (VALID !== 1'b1) begin $display("FAIL b2b_valid got %b want 1", VALID); miscompares++; end
        vectors++; if (AVG !== 16'd15) begin $display("FAIL b2b_avg got %0d want 15", AVG); miscompares++; end
        vectors++; if (OVR !== 1'b0) begin $display("FAIL b2b_ovr got %b want 0", OVR); miscompares++; end
        @(posedge CLK); #1;
        vectors++; if (VALID !== 1'b0) begin $display("FAIL b2b_drain got %b want 0", VALID); miscompares++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_mode_flush();
`ifdef MODE_NORM_EN
        test_saturation();
`endif
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
